// File: rtl/sync_ack_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_ack_feeder_pkg
// Brief    : Shared defaults for the sync_ack command feeder and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package sync_ack_feeder_pkg;

  // Default width of one command word
  localparam int DEFAULT_WIDTH      = 8;

  // Default queue depth is 2**DEFAULT_DEPTH_LOG2 words
  localparam int DEFAULT_DEPTH_LOG2 = 2;

endpackage : sync_ack_feeder_pkg
`default_nettype wire

// File: rtl/sync_ack_feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_ack_feeder_fifo
// Brief    : Circular command FIFO with wrapping pointers and a separate
//            occupancy counter. Writes while full are ignored; pops while
//            empty are ignored. The head word is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ack_feeder_fifo
  import sync_ack_feeder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Full is judged on the current occupancy, before any pop this cycle,
  // so a write arriving alongside a pop from a full queue is still dropped.
  assign full    = (level == DEPTH_LEVEL);
  assign push    = wr_en && !full;
  assign pop     = rd_en && (level != '0);
  assign rd_data = mem[rd_ptr];

  // Storage is not reset: its contents are only observable after a write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule : sync_ack_feeder_fifo
`default_nettype wire

// File: rtl/sync_ack_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sync_ack_feeder
// Brief    : Queues command words and hands them one at a time to a
//            sync_ack sender: a one-cycle sig pulse, then wait for busy to
//            rise and fall before the next word is considered.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ack_feeder
  import sync_ack_feeder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_wr,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                xfer_sig,
  input  logic                xfer_busy,
  output logic [WIDTH-1:0]    xfer_data,
  output logic                idle
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    SEND      = ST_SEND,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } state_t;

  state_t           state;
  logic             word_ready;
  logic             pop;
  logic [WIDTH-1:0] head;

  // The FSM looks at a registered "queue not empty" view, so a freshly
  // written word becomes eligible one cycle after it lands in the queue.
  assign pop  = (state == IDLE) && word_ready && !xfer_busy;
  assign idle = (state == IDLE) && (level == '0);

  sync_ack_feeder_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_wr),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full)
  );

  // One-cycle delayed occupancy view used by the IDLE decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_ready <= 1'b0;
    end else begin
      word_ready <= (level != '0);
    end
  end

  // Sticky record of any write attempted while the queue was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_wr && full) begin
      overflow <= 1'b1;
    end
  end

  // Transfer sequencer: xfer_sig is set on entry to SEND so it is high
  // exactly while the FSM sits in SEND; xfer_data holds until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      xfer_sig  <= 1'b0;
      xfer_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            xfer_data <= head;
            xfer_sig  <= 1'b1;
            state     <= SEND;
          end else begin
            xfer_sig  <= 1'b0;
          end
        end
        SEND: begin
          xfer_sig <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          xfer_sig <= 1'b0;
          if (xfer_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          xfer_sig <= 1'b0;
          if (!xfer_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          xfer_sig <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : sync_ack_feeder
`default_nettype wire

// File: tb/tb_sync_ack_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_ack_feeder
// Brief    : Directed self-checking bench for sync_ack_feeder with a simple
//            sync_ack busy model (busy rises 1 cycle after sig, lasts 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_ack_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_wr = 1'b0;
  logic       full;
  logic [2:0] level;
  logic       overflow;
  logic       xfer_sig;
  logic       xfer_busy = 1'b0;
  logic [7:0] xfer_data;
  logic       idle;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit auto_busy = 1'b0;
  int busy_cnt = 0;
  logic sig_prev = 1'b0;
  int doubles = 0;
  logic [7:0] got_q[$];
  int got_cyc[$];

  sync_ack_feeder #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_wr     (in_wr),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .xfer_sig  (xfer_sig),
    .xfer_busy (xfer_busy),
    .xfer_data (xfer_data),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Advance one cycle, run the busy model, and log every sig pulse.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_busy) begin
      if (busy_cnt > 0) busy_cnt--;
      if (sig_prev === 1'b1) busy_cnt = 6;
      xfer_busy = (busy_cnt > 0);
    end
    if (xfer_sig === 1'b1) begin
      got_q.push_back(xfer_data);
      got_cyc.push_back(cyc);
      if (sig_prev === 1'b1) doubles++;
    end
    sig_prev = xfer_sig;
  endtask

  task automatic do_reset();
    in_wr = 1'b0;
    auto_busy = 1'b0;
    busy_cnt = 0;
    xfer_busy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sig_prev = 1'b0;
    got_q.delete();
    got_cyc.delete();
    doubles = 0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if ({xfer_sig, full, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags sig/full/ovf=%b required 000", {xfer_sig, full, overflow}); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got %0d required 0", level); end
    checks++; if (xfer_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h required 00", xfer_data); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got %b required 1", idle); end
  endtask

  task automatic test_single();
    do_reset();
    auto_busy = 1'b1;
    in_data = 8'hA5; in_wr = 1'b1;
    step(); in_wr = 1'b0;                                   // cycle 1
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level_c1 got %0d required 1", level); end
    step();                                                 // cycle 2
    checks++; if (xfer_sig !== 1'b0) begin failures++; $display("FAIL single_sig_c2 got %b required 0", xfer_sig); end
    step();                                                 // cycle 3
    checks++; if (xfer_sig !== 1'b1) begin failures++; $display("FAIL single_sig_c3 got %b required 1", xfer_sig); end
    checks++; if (xfer_data !== 8'hA5) begin failures++; $display("FAIL single_data_c3 got %h required a5", xfer_data); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_level_c3 got %0d required 0", level); end
    step();                                                 // cycle 4
    checks++; if (xfer_sig !== 1'b0) begin failures++; $display("FAIL single_sig_c4 got %b required 0", xfer_sig); end
    repeat (6) step();                                      // cycle 10
    checks++; if (xfer_data !== 8'hA5) begin failures++; $display("FAIL single_data_c10 got %h required a5", xfer_data); end
    checks++; if (idle !== 1'b0) begin failures++; $display("FAIL single_idle_c10 got %b required 0", idle); end
    step();                                                 // cycle 11
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle_c11 got %b required 1", idle); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_pulses got %0d required 1", got_q.size()); end
  endtask

  task automatic test_burst();
    int r;
    do_reset();
    xfer_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1); in_wr = 1'b1;
      step();
    end
    in_wr = 1'b0;                                           // cycle 4
    checks++; if ({full, level} !== {1'b1, 3'd4}) begin failures++; $display("FAIL burst_full full=%b level=%0d required 1/4", full, level); end
    step(); step();
    r = cyc;
    xfer_busy = 1'b0; auto_busy = 1'b1;
    step();
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL burst_level_after_pop got %0d required 3", level); end
    repeat (44) step();
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL burst_pulses got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'(i + 1)) begin failures++; $display("FAIL burst_data[%0d] got %h required %h", i, got_q[i], 8'(i + 1)); end
      checks++; if (got_cyc[i] != r + 1 + 9 * i) begin failures++; $display("FAIL burst_time[%0d] got %0d required %0d", i, got_cyc[i], r + 1 + 9 * i); end
    end
    checks++; if (doubles != 0) begin failures++; $display("FAIL burst_single_cycle got %0d wide pulses required 0", doubles); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL burst_idle_end got %b required 1", idle); end
  endtask

  task automatic test_overflow();
    do_reset();
    xfer_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++; if ({full, overflow} !== 2'b10) begin failures++; $display("FAIL ovf_before full/ovf=%b required 10", {full, overflow}); end
      end
      in_data = 8'(i + 1); in_wr = 1'b1;
      step();
    end
    in_wr = 1'b0;                                           // cycle 5
    checks++; if ({full, overflow, level} !== {2'b11, 3'd4}) begin failures++; $display("FAIL ovf_after full/ovf/level=%b required 11100", {full, overflow, level}); end
    step();                                                 // cycle 6
    xfer_busy = 1'b0; auto_busy = 1'b1;
    in_data = 8'h66; in_wr = 1'b1;                          // dropped: full at the pop edge
    step(); in_wr = 1'b0;                                   // cycle 7
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL ovf_pop_drop level got %0d required 3", level); end
    repeat (40) step();
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_pulses got %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'(i + 1)) begin failures++; $display("FAIL ovf_data[%0d] got %h required %h", i, got_q[i], 8'(i + 1)); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b required 1", overflow); end
  endtask

  task automatic test_stuck_busy();
    int r;
    do_reset();
    xfer_busy = 1'b1;
    in_data = 8'h5A; in_wr = 1'b1;
    step(); in_wr = 1'b0;
    repeat (9) step();
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL stuck_no_sig got %0d pulses required 0", got_q.size()); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL stuck_level got %0d required 1", level); end
    r = cyc;
    xfer_busy = 1'b0; auto_busy = 1'b1;
    repeat (15) step();
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL stuck_pulses got %0d required 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h5A || got_cyc[0] != r + 1) begin failures++; $display("FAIL stuck_pulse data=%h cyc=%0d required 5a/%0d", got_q[0], got_cyc[0], r + 1); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    xfer_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h30 + i); in_wr = 1'b1;
      step();
    end
    in_wr = 1'b0;                                           // cycle 5
    xfer_busy = 1'b0; auto_busy = 1'b1;
    repeat (5) step();                                      // cycle 10: WAIT_DONE
    checks++; if ({xfer_data, level, overflow} !== {8'h30, 3'd3, 1'b1}) begin failures++; $display("FAIL midrst_pre data=%h level=%0d ovf=%b required 30/3/1", xfer_data, level, overflow); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({xfer_sig, full, overflow, idle} !== 4'b0001) begin failures++; $display("FAIL midrst_flags sig/full/ovf/idle=%b required 0001", {xfer_sig, full, overflow, idle}); end
    checks++; if ({xfer_data, level} !== 11'd0) begin failures++; $display("FAIL midrst_data data=%h level=%0d required 00/0", xfer_data, level); end
    auto_busy = 1'b0; busy_cnt = 0; xfer_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] v;
    do_reset();
    auto_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = 8'(i * 37 + 3);
      in_data = v; in_wr = 1'b1;
      step(); in_wr = 1'b0;
      n = 0;
      while (idle !== 1'b1 && n < 40) begin step(); n++; end
      checks++; if (n >= 40) begin failures++; $display("FAIL wrap_timeout[%0d] idle=%b required 1", i, idle); end
    end
    checks++; if (got_q.size() != 10) begin failures++; $display("FAIL wrap_pulses got %0d required 10", got_q.size()); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 8'(i * 37 + 3)) begin failures++; $display("FAIL wrap_data[%0d] got %h required %h", i, got_q[i], 8'(i * 37 + 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_stuck_busy();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sync_ack_feeder
`default_nettype wire
